// File: rtl/store_trace_buffer.sv
// Store trace buffer: captures core data-memory stores into a show-ahead FIFO for a trace sink.
// Optional capture timestamps are enabled with STORE_TRACE_TIMESTAMP_EN.
module store_trace_buffer #(
   parameter int unsigned DEPTH     = 8,
   parameter logic [31:0] DONE_ADR  = 32'd100,
   parameter logic [31:0] DONE_DATA = 32'd25
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_write,
   input  logic [31:0]              data_adr,
   input  logic [31:0]              write_data,
   output logic                     trace_valid,
   input  logic                     trace_ready,
   output logic [31:0]              trace_adr,
   output logic [31:0]              trace_data,
`ifdef STORE_TRACE_TIMESTAMP_EN
   output logic [15:0]              trace_ts,
`endif
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [7:0]               drop_cnt,
   output logic                     done
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   logic [31:0]   adr_mem  [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic          full, pop, push, drop;
   logic          load_mem, load_in;

`ifdef STORE_TRACE_TIMESTAMP_EN
   logic [15:0]   ts_mem [DEPTH];
   logic [15:0]   ts_cnt;
`endif

   assign full        = (count == FULL);
   assign trace_valid = (count != '0);
   assign pop         = trace_valid & trace_ready;
   assign push        = mem_write & (~full | pop);
   assign drop        = mem_write & full & ~pop;
   assign rd_next     = rd_ptr + AW'(1);

   // Head registers reload from RAM when another entry remains, or straight from the bus
   // when the incoming store becomes the new head (empty FIFO, or last entry popped).
   always_comb begin
      load_mem = 1'b0;
      load_in  = 1'b0;
      if (pop && (count > ONE)) begin
         load_mem = 1'b1;
      end else if (push && ((count == '0) || (pop && (count == ONE)))) begin
         load_in = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         adr_mem[wr_ptr]  <= data_adr;
         data_mem[wr_ptr] <= write_data;
`ifdef STORE_TRACE_TIMESTAMP_EN
         ts_mem[wr_ptr]   <= ts_cnt;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         trace_adr  <= '0;
         trace_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_next;
         if (push && !pop)      count <= count + ONE;
         else if (pop && !push) count <= count - ONE;
         if (load_mem) begin
            trace_adr  <= adr_mem[rd_next];
            trace_data <= data_mem[rd_next];
         end else if (load_in) begin
            trace_adr  <= data_adr;
            trace_data <= write_data;
         end
      end
   end

`ifdef STORE_TRACE_TIMESTAMP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_cnt   <= '0;
         trace_ts <= '0;
      end else begin
         ts_cnt <= ts_cnt + 16'd1;
         if (load_mem)     trace_ts <= ts_mem[rd_next];
         else if (load_in) trace_ts <= ts_cnt;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
         done     <= 1'b0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
         end
         // Completion is flagged even if the store itself is dropped.
         if (mem_write && (data_adr == DONE_ADR) && (write_data == DONE_DATA)) begin
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_store_trace_buffer.sv
// Self-checking bench for store_trace_buffer: vector table plus multi-cycle corner sequences.
module tb_store_trace_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_write;
   logic [31:0] data_adr;
   logic [31:0] write_data;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_adr;
   logic [31:0] trace_data;
   logic [3:0]  count;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        done;
`ifdef STORE_TRACE_TIMESTAMP_EN
   logic [15:0] trace_ts;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   store_trace_buffer #(
      .DEPTH     (8),
      .DONE_ADR  (32'd100),
      .DONE_DATA (32'd25)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_write   (mem_write),
      .data_adr    (data_adr),
      .write_data  (write_data),
      .trace_valid (trace_valid),
      .trace_ready (trace_ready),
      .trace_adr   (trace_adr),
      .trace_data  (trace_data),
`ifdef STORE_TRACE_TIMESTAMP_EN
      .trace_ts    (trace_ts),
`endif
      .count       (count),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mw;
      logic [31:0] adr;
      logic [31:0] data;
      logic        rdy;
      logic        e_valid;
      logic [31:0] e_adr;
      logic [31:0] e_data;
      logic [3:0]  e_count;
      logic        e_done;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] dat,
                        input logic rdy);
      mem_write   = mw;
      data_adr    = adr;
      write_data  = dat;
      trace_ready = rdy;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 32'd96,  32'd7,  1'b0, 1'b1, 32'd96,  32'd7,  4'd1, 1'b0};
      vecs[1] = '{1'b1, 32'd100, 32'd25, 1'b0, 1'b1, 32'd96,  32'd7,  4'd2, 1'b1};
      vecs[2] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b1, 32'd100, 32'd25, 4'd1, 1'b1};
      vecs[3] = '{1'b1, 32'd50,  32'd5,  1'b1, 1'b1, 32'd50,  32'd5,  4'd1, 1'b1};
      vecs[4] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 32'd50,  32'd5,  4'd0, 1'b1};
      vecs[5] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 32'd50,  32'd5,  4'd0, 1'b1};
      vecs[6] = '{1'b1, 32'd8,   32'd3,  1'b0, 1'b1, 32'd8,   32'd3,  4'd1, 1'b1};

      reset = 1'b1;
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      #2;
      reset = 1'b0;
      #3;
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(trace_valid), 32'd0);
      check("rst_adr", trace_adr, 32'd0);
      check("rst_data", trace_data, 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Table: single store, completion store, pops, push+pop at count 1, ready while empty
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].mw, vecs[i].adr, vecs[i].data, vecs[i].rdy);
         tick();
         check($sformatf("vec%0d_valid", i), 32'(trace_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d_adr", i), trace_adr, vecs[i].e_adr);
         check($sformatf("vec%0d_data", i), trace_data, vecs[i].e_data);
         check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
         check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      end
      check("vec_overflow", 32'(overflow), 32'd0);

      // done cleared only by reset
      do_reset();
      check("done_after_reset", 32'(done), 32'd0);

      // Fill and overflow
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'(i), 32'(i + 1), 1'b0);
         tick();
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      tick();
      check("fill_count", 32'(count), 32'd8);
      check("fill_overflow", 32'(overflow), 32'd1);
      check("fill_drop_cnt", 32'(drop_cnt), 32'd2);
      check("fill_head_stable", trace_adr, 32'd0);
      trace_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_adr%0d", i), trace_adr, 32'(i));
         check($sformatf("drain_data%0d", i), trace_data, 32'(i + 1));
         tick();
      end
      check("drain_count", 32'(count), 32'd0);
      check("drain_valid", 32'(trace_valid), 32'd0);

      // Push and pop together while full
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'(i), 32'd0, 1'b0);
         tick();
      end
      drive(1'b1, 32'd200, 32'd1, 1'b1);
      tick();
      check("fullpp_count", 32'(count), 32'd8);
      check("fullpp_overflow", 32'(overflow), 32'd0);
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("fullpp_pop%0d", i), trace_adr, (i == 8) ? 32'd200 : 32'(i));
         tick();
      end
      check("fullpp_empty", 32'(count), 32'd0);

      // Pointer wrap streaming, then drop-count saturation
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 32'(i), 32'(i), 1'b1);
         tick();
         if (trace_adr !== 32'(i) || trace_data !== 32'(i) || count !== 4'd1)
            check($sformatf("stream%0d", i), trace_adr, 32'(i));
      end
      check("stream_count", 32'(count), 32'd1);
      check("stream_tail", trace_data, 32'd299);
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      tick();
      check("stream_empty", 32'(count), 32'd0);
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 32'(i), 32'(i), 1'b0);
         tick();
      end
      check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
      check("sat_overflow", 32'(overflow), 32'd1);
      check("sat_count", 32'(count), 32'd8);

      // Asynchronous reset mid-operation
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'(10 + i), 32'(i), 1'b0);
         tick();
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      check("mid_count5", 32'(count), 32'd5);
      #1;
      reset = 1'b0;
      #1;
      check("mid_async_count", 32'(count), 32'd0);
      check("mid_async_valid", 32'(trace_valid), 32'd0);
      check("mid_async_adr", trace_adr, 32'd0);
      check("mid_async_data", trace_data, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 32'd4, 32'd9, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      check("mid_new_valid", 32'(trace_valid), 32'd1);
      check("mid_new_adr", trace_adr, 32'd4);
      check("mid_new_data", trace_data, 32'd9);
      check("mid_new_count", 32'(count), 32'd1);
`ifdef STORE_TRACE_TIMESTAMP_EN
      check("mid_new_ts", 32'(trace_ts), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
